param_updown_counter: RTL and testbench
=======================================

// Module: param_updown_counter
//
// PURPOSE
//   Parametrised successor to the team's 4-bit enable counter. Adds:
//     - configurable width and modulus
//     - up/down direction
//     - parallel load
//     - wrap or saturate mode
//     - enable prescaler
//     - terminal-count pulse and sticky overflow flag
//   Instantiated under the tt_um_* top. ui_in bits drive the controls; count/tc/ovf drive uo_out.
//
// PARAMETERS
//   WIDTH      8              counter width in bits (>=1)
//   MAX_COUNT  2**WIDTH-1     highest count value; count range 0..MAX_COUNT (must fit in WIDTH bits)
//   PRESCALE   1              enabled clk cycles per count step (>=1; 1 = step every enabled cycle)
//   RESET_VAL  0              count value after reset (must be <= MAX_COUNT)
//
// PORTS
//   clk       in   1      clock, all state on rising edge
//   rst       in   1      synchronous reset, active-high
//   en        in   1      count enable; prescaler advances only while en=1
//   up        in   1      direction: 1 = increment, 0 = decrement
//   load      in   1      parallel load strobe
//   load_val  in   WIDTH  value loaded when load=1
//   mode_sat  in   1      0 = wrap at bounds, 1 = saturate at bounds
//   clr_ovf   in   1      clears sticky ovf
//   count     out  WIDTH  current count (registered)
//   tc        out  1      terminal-count pulse (registered, 1 cycle)
//   ovf       out  1      sticky boundary-hit flag (registered)
//
// BEHAVIOUR
//   Reset (rst=1 at edge): count=RESET_VAL, pre_cnt=0, tc=0, ovf=0. Mid-operation reset overrides everything.
//   Priority per edge: rst > load > step > hold.
//   Prescaler pre_cnt (width $clog2(PRESCALE), min 1 bit):
//     - step = en && (pre_cnt == PRESCALE-1)
//     - if en: pre_cnt <= step ? 0 : pre_cnt+1
//     - if !en: pre_cnt holds
//     - load forces pre_cnt <= 0
//   Load: count <= min(load_val, MAX_COUNT) (unsigned compare). Load never asserts tc and never sets ovf.
//   Step, up=1:
//     - count < MAX_COUNT: count+1
//     - count == MAX_COUNT, boundary: wrap -> 0; sat -> hold MAX_COUNT
//   Step, up=0:
//     - count > 0: count-1
//     - count == 0, boundary: wrap -> MAX_COUNT; sat -> hold 0
//   Boundary step (either mode, either direction):
//     - tc <= 1 for exactly one cycle, coincident with the new count value
//     - ovf <= 1
//     - in sat mode tc re-pulses on every further step attempted at the bound
//   tc <= 0 on every edge without a boundary step.
//   ovf is cleared only by clr_ovf or rst. clr_ovf and a boundary step on the same edge: ovf=1 (set wins).
//   up and mode_sat are sampled only on step edges and may change freely between steps.
//   Latency: count, tc and ovf all update at the edge where step/load is taken; no combinational input->output paths.
//   MAX_COUNT = 2**WIDTH-1: wrap is the natural modulo-2^WIDTH wrap. Internal arithmetic is WIDTH bits; no carry escapes.
//
// TESTING (bench uses WIDTH=4, MAX_COUNT=9, RESET_VAL=0 unless noted)
//   1. rst=1 1 cycle, then en=1 up=1 mode_sat=0 for 12 cycles
//      -> count 1..9,0,1,2; tc=1 only with count=0; ovf=1 from then on.
//   2. load=1 load_val=3, then en=1 up=0 mode_sat=1 for 5 cycles
//      -> count 3,2,1,0,0,0; tc pulses on the last two steps; ovf=1.
//   3. load_val=15 (>MAX_COUNT) with load=1 and en=1 on the same edge
//      -> count=9, tc=0, ovf unchanged; load beats step.
//   4. PRESCALE=3, en=1 up=1 from 0; drop en for 2 cycles mid-run
//      -> count increments every 3rd enabled cycle; prescaler holds while en=0.
//   5. count=9 with ovf=0; step up (wrap) and clr_ovf=1 on the same edge
//      -> count=0, tc=1, ovf=1; clr_ovf next cycle -> ovf=0.
//   6. rst=1 asserted mid-count with load=1 and en=1
//      -> next cycle count=0, tc=0, ovf=0, pre_cnt=0.

Source files
------------

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with parallel load, wrap/saturate bounds,
// enable prescaler, one-cycle terminal-count pulse and sticky overflow flag.
// Priority on each rising edge: rst > load > step > hold.
module param_updown_counter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_COUNT = (2 ** WIDTH) - 1,
    parameter int unsigned PRESCALE  = 1,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode_sat,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    // Prescaler needs at least one bit even when PRESCALE is 1.
    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] RST_C   = WIDTH'(RESET_VAL);
    localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(PRESCALE - 1);
    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);
    localparam logic [WIDTH-1:0] ONE_C   = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic [PRE_W-1:0] r_pre_cnt;
    logic             r_tc;
    logic             r_ovf;

    logic             w_step;
    logic             w_at_bound;
    logic             w_bound_step;
    logic [WIDTH-1:0] w_step_val;
    logic [WIDTH-1:0] w_load_val;

    assign w_step       = en && (r_pre_cnt == PRE_TOP);
    assign w_bound_step = w_step && w_at_bound && !load;
    // Out-of-range load values clamp to the top of the count range.
    assign w_load_val   = (load_val > MAX_C) ? MAX_C : load_val;

    // Next count for a step: move one towards the bound, then wrap or hold there.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_at_bound = 1'b0;
        w_step_val = r_count;
        if (up) begin
            if (r_count == MAX_C) begin
                w_at_bound = 1'b1;
                w_step_val = mode_sat ? MAX_C : '0;
            end else begin
                w_step_val = r_count + ONE_C;
            end
        end else begin
            if (r_count == '0) begin
                w_at_bound = 1'b1;
                w_step_val = mode_sat ? '0 : MAX_C;
            end else begin
                w_step_val = r_count - ONE_C;
            end
        end
    end

    // Count, prescaler and terminal-count pulse.
    always_ff @(posedge clk) begin
        // NOTE: state is written with <= so every register samples pre-edge values, whatever the statement order.
        if (rst) begin
            r_count   <= RST_C;
            r_pre_cnt <= '0;
            r_tc      <= 1'b0;
        end else if (load) begin
            r_count   <= w_load_val;
            r_pre_cnt <= '0;
            r_tc      <= 1'b0;
        end else begin
            if (en) begin
                r_pre_cnt <= w_step ? '0 : (r_pre_cnt + PRE_ONE);
            end
            if (w_step) begin
                r_count <= w_step_val;
            end
            r_tc <= w_bound_step;
        end
    end

    // Sticky overflow: a boundary step sets it and beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_bound_step) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: WIDTH=4, MAX_COUNT=9, RESET_VAL=0,
// one instance with PRESCALE=1 and one with PRESCALE=3 sharing all inputs.
module tb_param_updown_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic       mode_sat = 1'b0;
    logic       clr_ovf = 1'b0;

    logic [3:0] count;
    logic       tc;
    logic       ovf;
    logic [3:0] p_count;
    logic       p_tc;
    logic       p_ovf;

    int n_vec = 0;
    int n_err = 0;

    param_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(1), .RESET_VAL(0)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .mode_sat(mode_sat), .clr_ovf(clr_ovf), .count(count), .tc(tc), .ovf(ovf)
    );

    param_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(3), .RESET_VAL(0)) dut_pre (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .mode_sat(mode_sat), .clr_ovf(clr_ovf), .count(p_count), .tc(p_tc), .ovf(p_ovf)
    );

    always #5 clk = ~clk;

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0;
        load_val = '0; mode_sat = 1'b0; clr_ovf = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd7;
        tick();
        n_vec++;
        if (count !== 4'd0 || tc !== 1'b0 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset: count=%0d tc=%b ovf=%b, want count=0 tc=0 ovf=0", count, tc, ovf);
        end
        n_vec++;
        if (p_count !== 4'd0 || p_tc !== 1'b0 || p_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_pre: count=%0d tc=%b ovf=%b, want count=0 tc=0 ovf=0", p_count, p_tc, p_ovf);
        end
    endtask

    // Wrap up through MAX_COUNT: 1..9,0,1,2; tc only with the 0.
    task automatic test_wrap_up();
        logic [3:0] exp_c [12];
        logic       exp_tc [12];
        logic       exp_ovf [12];
        exp_c   = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
        exp_tc  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        exp_ovf = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
        set_idle();
        en = 1'b1; up = 1'b1; mode_sat = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_vec++;
            if (count !== exp_c[i] || tc !== exp_tc[i] || ovf !== exp_ovf[i]) begin
                n_err++;
                $display("FAIL wrap_up[%0d]: count=%0d tc=%b ovf=%b, want count=%0d tc=%b ovf=%b",
                         i, count, tc, ovf, exp_c[i], exp_tc[i], exp_ovf[i]);
            end
        end
    endtask

    // Load 3 then saturate downwards: 2,1,0,0,0 with tc on the last two.
    task automatic test_sat_down();
        logic [3:0] exp_c [5];
        logic       exp_tc [5];
        exp_c  = '{4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
        exp_tc = '{0, 0, 0, 1, 1};
        set_idle();
        load = 1'b1; load_val = 4'd3;
        tick();
        n_vec++;
        if (count !== 4'd3 || tc !== 1'b0 || ovf !== 1'b1) begin
            n_err++;
            $display("FAIL sat_load: count=%0d tc=%b ovf=%b, want count=3 tc=0 ovf=1", count, tc, ovf);
        end
        load = 1'b0; en = 1'b1; up = 1'b0; mode_sat = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++;
            if (count !== exp_c[i] || tc !== exp_tc[i] || ovf !== 1'b1) begin
                n_err++;
                $display("FAIL sat_down[%0d]: count=%0d tc=%b ovf=%b, want count=%0d tc=%b ovf=1",
                         i, count, tc, ovf, exp_c[i], exp_tc[i]);
            end
        end
    endtask

    // Clear ovf, then load 15 with en=1: clamp to 9, no tc, ovf stays 0.
    task automatic test_load_clamp();
        set_idle();
        clr_ovf = 1'b1;
        tick();
        n_vec++;
        if (ovf !== 1'b0 || tc !== 1'b0 || count !== 4'd0) begin
            n_err++;
            $display("FAIL clr_ovf: count=%0d tc=%b ovf=%b, want count=0 tc=0 ovf=0", count, tc, ovf);
        end
        clr_ovf = 1'b0; load = 1'b1; load_val = 4'd15; en = 1'b1; up = 1'b1;
        tick();
        n_vec++;
        if (count !== 4'd9 || tc !== 1'b0 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL load_clamp: count=%0d tc=%b ovf=%b, want count=9 tc=0 ovf=0", count, tc, ovf);
        end
    endtask

    // From 9 with ovf=0: wrap step with clr_ovf on the same edge, set wins.
    task automatic test_ovf_set_wins();
        set_idle();
        en = 1'b1; up = 1'b1; mode_sat = 1'b0; clr_ovf = 1'b1;
        tick();
        n_vec++;
        if (count !== 4'd0 || tc !== 1'b1 || ovf !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set_wins: count=%0d tc=%b ovf=%b, want count=0 tc=1 ovf=1", count, tc, ovf);
        end
        en = 1'b0;
        tick();
        n_vec++;
        if (count !== 4'd0 || tc !== 1'b0 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear_after: count=%0d tc=%b ovf=%b, want count=0 tc=0 ovf=0", count, tc, ovf);
        end
    endtask

    // PRESCALE=3 instance: step every 3rd enabled cycle, prescaler frozen while en=0.
    task automatic test_prescale();
        logic       en_seq [11];
        logic [3:0] exp_c [11];
        en_seq = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
        exp_c  = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd3};
        set_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0; up = 1'b1;
        for (int i = 0; i < 11; i++) begin
            en = en_seq[i];
            tick();
            n_vec++;
            if (p_count !== exp_c[i] || p_tc !== 1'b0) begin
                n_err++;
                $display("FAIL prescale[%0d]: count=%0d tc=%b, want count=%0d tc=0", i, p_count, p_tc, exp_c[i]);
            end
        end
    endtask

    // Reset mid-count with load and en asserted clears everything, prescaler included.
    task automatic test_mid_reset();
        logic [3:0] exp_p [3];
        exp_p = '{4'd0, 4'd0, 4'd1};
        set_idle();
        load = 1'b1; load_val = 4'd9;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        // Main wraps to 0 then counts to 3; PRESCALE instance wraps at its 3rd step cycle, pre_cnt left at 1.
        for (int i = 0; i < 4; i++) tick();
        n_vec++;
        if (count !== 4'd3 || ovf !== 1'b1 || p_count !== 4'd0 || p_ovf !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset_setup: count=%0d ovf=%b p_count=%0d p_ovf=%b, want 3 1 0 1",
                     count, ovf, p_count, p_ovf);
        end
        rst = 1'b1; load = 1'b1; load_val = 4'd5; en = 1'b1;
        tick();
        n_vec++;
        if (count !== 4'd0 || tc !== 1'b0 || ovf !== 1'b0 || p_count !== 4'd0 || p_tc !== 1'b0 || p_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: count=%0d tc=%b ovf=%b p_count=%0d p_tc=%b p_ovf=%b, want all 0",
                     count, tc, ovf, p_count, p_tc, p_ovf);
        end
        rst = 1'b0; load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (p_count !== exp_p[i] || count !== 4'(i + 1)) begin
                n_err++;
                $display("FAIL post_reset[%0d]: count=%0d p_count=%0d, want count=%0d p_count=%0d",
                         i, count, p_count, i + 1, exp_p[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_load_clamp();
        test_ovf_set_wins();
        test_prescale();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, want finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
